// File: rtl/plic_pkg.sv
// plic_pkg: shared constants and types for the multi-context PLIC core.
//   Register-map byte offsets on the 24-bit register bus, default sizing, and
//   convenience types for interrupt IDs and priorities at the default sizing.
package plic_pkg;

  localparam int unsigned DEF_NSRC   = 128;
  localparam int unsigned DEF_NCTX   = 2;
  localparam int unsigned DEF_PRIO_W = 3;
  localparam int unsigned DEF_ID_W   = $clog2(DEF_NSRC);

  localparam logic [23:0] PRIO_BASE  = 24'h000000;
  localparam logic [23:0] PEND_BASE  = 24'h001000;
  localparam logic [23:0] MODE_BASE  = 24'h001080;
  localparam logic [23:0] EN_BASE    = 24'h002000;
  localparam logic [23:0] EN_STRIDE  = 24'h000080;
  localparam logic [23:0] CTX_BASE   = 24'h200000;
  localparam logic [23:0] CTX_STRIDE = 24'h001000;
  localparam logic [23:0] CLAIM_OFS  = 24'h000004;

  typedef logic [DEF_ID_W-1:0]   id_t;
  typedef logic [DEF_PRIO_W-1:0] prio_t;

endpackage

// File: rtl/plic_if.sv
// plic_if: 24-bit address / 32-bit data register bus.
//   wen, ren : write / read strobes (never both high)
//   addr     : word-aligned byte address
//   wdata    : write data
//   rdata    : combinational read data, 0 when ren is low
interface plic_if;
  logic        wen;
  logic        ren;
  logic [23:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output wen, output ren, output addr, output wdata, input rdata);
  modport slave  (input wen, input ren, input addr, input wdata, output rdata);
endinterface

// File: rtl/plic_gateway.sv
// plic_gateway: one interrupt source's gateway.
//   clk, rst   : clock, synchronous active-high reset
//   req        : raw interrupt line
//   edge_mode  : 1 = rising-edge triggered, 0 = level triggered
//   claim_clr  : clears pending (a context claimed this ID)
//   complete   : clears in-flight (a context completed this ID)
//   pending    : pending flag
//   in_flight  : set together with pending, held until completion
module plic_gateway (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic edge_mode,
  input  logic claim_clr,
  input  logic complete,
  output logic pending,
  output logic in_flight
);

  logic req_q;
  logic pend_q, pend_d;
  logic infl_q, infl_d;
  logic set;

  // In-flight blocks new requests in both modes, so edges seen while
  // in-flight are simply lost.
  assign set = ~infl_q & (edge_mode ? (req & ~req_q) : req);

  always_comb begin
    pend_d = pend_q;
    infl_d = infl_q;
    if (claim_clr)  pend_d = 1'b0;
    else if (set)   pend_d = 1'b1;
    if (complete)   infl_d = 1'b0;
    else if (set)   infl_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q  <= 1'b0;
      pend_q <= 1'b0;
      infl_q <= 1'b0;
    end else begin
      req_q  <= req;
      pend_q <= pend_d;
      infl_q <= infl_d;
    end
  end

  assign pending   = pend_q;
  assign in_flight = infl_q;

endmodule

// File: rtl/plic_core_mc.sv
// plic_core_mc: multi-context platform-level interrupt controller core.
//   clk, rst : clock, synchronous active-high reset
//   int_req  : raw source lines, bit 0 ignored (ID 0 reserved)
//   bus      : register bus (slave side), rdata combinational
//   notif    : registered per-context interrupt-pending to the core
//   int_end  : one-cycle completion pulse per source ID
module plic_core_mc
  import plic_pkg::*;
#(
  parameter int unsigned NSRC   = DEF_NSRC,
  parameter int unsigned NCTX   = DEF_NCTX,
  parameter int unsigned PRIO_W = DEF_PRIO_W,
  parameter int unsigned ID_W   = $clog2(NSRC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] int_req,
  plic_if.slave           bus,
  output logic [NCTX-1:0] notif,
  output logic [NSRC-1:0] int_end
);

  localparam int unsigned NWORD  = NSRC / 32;
  localparam int unsigned WORD_W = (NWORD > 1) ? $clog2(NWORD) : 1;
  localparam int unsigned CTX_W  = (NCTX > 1) ? $clog2(NCTX) : 1;

  // State
  logic [NSRC-1:0][PRIO_W-1:0] prio_q;
  logic [NSRC-1:0]             mode_q;
  logic [NCTX-1:0][NSRC-1:0]   en_q;
  logic [NCTX-1:0][PRIO_W-1:0] thr_q;
  logic [NCTX-1:0]             notif_q, notif_d;
  logic [NSRC-1:0]             int_end_q;

  logic [NSRC-1:0] pending, in_flight, claim_clr, cpl;
  logic [ID_W-1:0] winner [NCTX];

  // Address decode: offsets from each base wrap to huge values below the
  // base, so a single upper-bound compare per region is enough.
  logic [23:0]       prio_off, pend_off, mode_off, en_off, c_off, c_reg;
  logic              is_prio, is_pend, is_mode, is_en, is_ctx, is_thr, is_claim;
  logic [ID_W-1:0]   prio_id;
  logic [WORD_W-1:0] pend_w, mode_w, en_w;
  logic [CTX_W-1:0]  en_ctx, c_ctx;

  assign prio_off = bus.addr - PRIO_BASE;
  assign pend_off = bus.addr - PEND_BASE;
  assign mode_off = bus.addr - MODE_BASE;
  assign en_off   = bus.addr - EN_BASE;
  assign c_off    = bus.addr - CTX_BASE;
  assign c_reg    = c_off % CTX_STRIDE;

  assign is_prio  = prio_off < 24'(NSRC * 4);
  assign is_pend  = pend_off < 24'(NWORD * 4);
  assign is_mode  = mode_off < 24'(NWORD * 4);
  assign is_en    = (en_off < EN_STRIDE * 24'(NCTX)) && ((en_off % EN_STRIDE) < 24'(NWORD * 4));
  assign is_ctx   = c_off < CTX_STRIDE * 24'(NCTX);
  assign is_thr   = is_ctx && (c_reg == '0);
  assign is_claim = is_ctx && (c_reg == CLAIM_OFS);

  assign prio_id = ID_W'(prio_off >> 2);
  assign pend_w  = WORD_W'(pend_off >> 2);
  assign mode_w  = WORD_W'(mode_off >> 2);
  assign en_w    = WORD_W'((en_off % EN_STRIDE) >> 2);
  assign en_ctx  = CTX_W'(en_off / EN_STRIDE);
  assign c_ctx   = CTX_W'(c_off / CTX_STRIDE);

  // Highest priority above threshold wins; the strict compare while scanning
  // upward keeps the lowest ID on ties and excludes priority 0.
  function automatic logic [ID_W-1:0] arbitrate(
    input logic [NSRC-1:0]             pend,
    input logic [NSRC-1:0]             en,
    input logic [NSRC-1:0][PRIO_W-1:0] prio,
    input logic [PRIO_W-1:0]           thr
  );
    logic [PRIO_W-1:0] best;
    logic [ID_W-1:0]   id;
    best = thr;
    id   = '0;
    for (int unsigned i = 1; i < NSRC; i++) begin
      if (pend[i] && en[i] && (prio[i] > best)) begin
        best = prio[i];
        id   = ID_W'(i);
      end
    end
    return id;
  endfunction

  always_comb begin
    notif_d = '0;
    for (int c = 0; c < NCTX; c++) begin
      winner[c]  = arbitrate(pending, en_q[c], prio_q, thr_q[c]);
      notif_d[c] = winner[c] != '0;
    end
  end

  // Claim / complete
  logic [ID_W-1:0] cpl_id;
  logic            cpl_ok;

  assign cpl_id = bus.wdata[ID_W-1:0];
  assign cpl_ok = (cpl_id != '0) && (32'(cpl_id) < NSRC) && en_q[c_ctx][cpl_id]
                  && in_flight[cpl_id];

  always_comb begin
    claim_clr = '0;
    cpl       = '0;
    if (bus.ren && is_claim && (winner[c_ctx] != '0)) claim_clr[winner[c_ctx]] = 1'b1;
    if (bus.wen && is_claim && cpl_ok)                cpl[cpl_id] = 1'b1;
  end

  // Gateways
  assign pending[0]   = 1'b0;
  assign in_flight[0] = 1'b0;

  for (genvar g = 1; g < NSRC; g++) begin : g_gw
    plic_gateway u_gw (
      .clk       (clk),
      .rst       (rst),
      .req       (int_req[g]),
      .edge_mode (mode_q[g]),
      .claim_clr (claim_clr[g]),
      .complete  (cpl[g]),
      .pending   (pending[g]),
      .in_flight (in_flight[g])
    );
  end

  // Register writes
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q    <= '0;
      mode_q    <= '0;
      en_q      <= '0;
      thr_q     <= '0;
      notif_q   <= '0;
      int_end_q <= '0;
    end else begin
      if (bus.wen) begin
        if (is_prio && (prio_id != '0)) prio_q[prio_id] <= bus.wdata[PRIO_W-1:0];
        // Bit 0 of word 0 belongs to the reserved ID and stays 0.
        if (is_mode) mode_q[{mode_w, 5'b0} +: 32] <= bus.wdata & {31'h7fff_ffff, mode_w != '0};
        if (is_en) en_q[en_ctx][{en_w, 5'b0} +: 32] <= bus.wdata & {31'h7fff_ffff, en_w != '0};
        if (is_thr) thr_q[c_ctx] <= bus.wdata[PRIO_W-1:0];
      end
      notif_q   <= notif_d;
      int_end_q <= cpl;
    end
  end

  // Register reads
  always_comb begin
    bus.rdata = '0;
    if (bus.ren) begin
      if (is_prio)       bus.rdata = 32'(prio_q[prio_id]);
      else if (is_pend)  bus.rdata = pending[{pend_w, 5'b0} +: 32];
      else if (is_mode)  bus.rdata = mode_q[{mode_w, 5'b0} +: 32];
      else if (is_en)    bus.rdata = en_q[en_ctx][{en_w, 5'b0} +: 32];
      else if (is_thr)   bus.rdata = 32'(thr_q[c_ctx]);
      else if (is_claim) bus.rdata = 32'(winner[c_ctx]);
    end
  end

  assign notif   = notif_q;
  assign int_end = int_end_q;

  logic unused_bits;
  assign unused_bits = ^{int_req[0], claim_clr[0], mode_q[0]};

endmodule
